// File: rtl/flash_spi_master.sv
// flash_spi_master: issues one SPI mode-0 READ transaction to a NOR flash
// per request and returns the 32-bit little-endian word read back.
// Optional build macro: FLASH_FAST_READ_EN selects FAST_READ (0x0B) with
// eight dummy SCK cycles between the address and the data phase.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for req_i, flash deselected
// S_CS_SETUP | csn low, CLK_DIV cycles before the first SCK edge
// S_CMD      | shifting out the 8-bit command
// S_ADDR     | shifting out the byte address, MSB first
// S_DUMMY    | eight dummy SCK cycles (fast read only), mosi held low
// S_DATA     | shifting in 32 data bits on rising SCK
// S_CS_HOLD  | SCK low for CLK_DIV cycles, csn released on the last one
// S_ACK      | ack_o pulse, data_o freshly loaded
// S_CS_GAP   | csn high for CLK_DIV cycles of minimum deselect time

module flash_spi_master #(
    parameter int CLK_DIV    = 2,
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  busy_o,
    output logic                  ack_o,
    output logic [31:0]           data_o,
    output logic                  flash_csn,
    output logic                  flash_clk,
    output logic                  flash_mosi,
    input  logic                  flash_miso,
    output logic                  flash_wpn,
    output logic                  flash_holdn
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CS_SETUP,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_CS_HOLD,
        S_ACK,
        S_CS_GAP
    } state_t;

    localparam int HDR_W = 8 + ADDR_WIDTH;
`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] CMD_CODE = 8'h0B;
`else
    localparam logic [7:0] CMD_CODE = 8'h03;
`endif
    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         div_q;
    logic               sck_q;
    logic [5:0]         bit_q;
    logic [5:0]         bit_load;
    logic [HDR_W-1:0]   sh_out_q;
    logic [31:0]        sh_in_q;
    logic [31:0]        data_q;

    logic               div_done;
    logic               in_bits;
    logic               rise;
    logic               cell_end;
    logic               last_bit;

    // Half-period timer terminal count and bit-cell boundary decode.
    always_comb begin
        div_done = (div_q == 8'd0);
        in_bits  = (state_q == S_CMD) || (state_q == S_ADDR) ||
                   (state_q == S_DUMMY) || (state_q == S_DATA);
        rise     = in_bits && div_done && !sck_q;
        cell_end = in_bits && div_done && sck_q;
        last_bit = (bit_q == 6'd0);
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (req_i) state_d = S_CS_SETUP;
            S_CS_SETUP: if (div_done) state_d = S_CMD;
            S_CMD:      if (cell_end && last_bit) state_d = S_ADDR;
            S_ADDR: begin
                if (cell_end && last_bit) begin
`ifdef FLASH_FAST_READ_EN
                    state_d = S_DUMMY;
`else
                    state_d = S_DATA;
`endif
                end
            end
            S_DUMMY:    if (cell_end && last_bit) state_d = S_DATA;
            S_DATA:     if (cell_end && last_bit) state_d = S_CS_HOLD;
            S_CS_HOLD:  if (div_done) state_d = S_ACK;
            S_ACK:      state_d = S_CS_GAP;
            S_CS_GAP:   if (div_done) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Bit counter reload value for the phase being entered.
    always_comb begin
        bit_load = 6'd0;
        case (state_d)
            S_CMD:   bit_load = 6'd7;
            S_ADDR:  bit_load = 6'(ADDR_WIDTH - 1);
            S_DUMMY: bit_load = 6'd7;
            S_DATA:  bit_load = 6'd31;
            default: bit_load = 6'd0;
        endcase
    end

    // Timer, SCK, shift registers and the returned word.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_q    <= 8'd0;
            sck_q    <= 1'b0;
            bit_q    <= 6'd0;
            sh_out_q <= '0;
            sh_in_q  <= 32'd0;
            data_q   <= 32'd0;
        end else begin
            // Every state entry and every half-cell end restarts the timer.
            div_q <= (state_d != state_q || div_done) ? DIV_LOAD : div_q - 8'd1;

            if (in_bits && div_done) begin
                sck_q <= ~sck_q;
            end else if (!in_bits) begin
                sck_q <= 1'b0;
            end

            if (state_q == S_IDLE && req_i) begin
                sh_out_q <= {CMD_CODE, addr_i};
            end else if (cell_end && (state_q == S_CMD || state_q == S_ADDR)) begin
                sh_out_q <= {sh_out_q[HDR_W-2:0], 1'b0};
            end

            if (rise && state_q == S_DATA) begin
                sh_in_q <= {sh_in_q[30:0], flash_miso};
            end

            if ((state_q == S_CS_SETUP && div_done) || (cell_end && last_bit)) begin
                bit_q <= bit_load;
            end else if (cell_end) begin
                bit_q <= bit_q - 6'd1;
            end

            // First byte on the wire lands in the low byte.
            if (state_q == S_CS_HOLD && div_done) begin
                data_q <= {sh_in_q[7:0], sh_in_q[15:8], sh_in_q[23:16], sh_in_q[31:24]};
            end
        end
    end

    // Moore outputs; csn releases on the final CS_HOLD cycle.
    always_comb begin
        flash_csn  = 1'b1;
        flash_mosi = 1'b0;
        busy_o     = 1'b0;
        ack_o      = 1'b0;
        case (state_q)
            S_CS_SETUP, S_DUMMY, S_DATA: begin
                flash_csn = 1'b0;
                busy_o    = 1'b1;
            end
            S_CMD, S_ADDR: begin
                flash_csn  = 1'b0;
                busy_o     = 1'b1;
                flash_mosi = sh_out_q[HDR_W-1];
            end
            S_CS_HOLD: begin
                flash_csn = div_done;
                busy_o    = 1'b1;
            end
            S_ACK: begin
                busy_o = 1'b1;
                ack_o  = 1'b1;
            end
            default: begin
                flash_csn = 1'b1;
            end
        endcase
    end

    assign flash_clk   = sck_q;
    assign data_o      = data_q;
    assign flash_wpn   = 1'b1;
    assign flash_holdn = 1'b1;

endmodule
